// File: rtl/occupancy_grid_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : occupancy_grid_pkg
//  Description : Shared types for the occupancy-grid port arbiter: the
//                arbiter state encoding and the latched cell-request record.
//  Revision    : 1.0 - initial release
// ============================================================================
package occupancy_grid_pkg;

    // Cell coordinate widths of the grid this codebase targets. The arbiter's
    // geometry parameters default to these and must not exceed them.
    localparam int CELL_X_W = 8;
    localparam int CELL_Y_W = 8;

    // Arbiter sequencing: accept -> one-cycle issue -> stale-ready hold -> wait
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    // Request fields captured at accept time and replayed to the grid
    typedef struct packed {
        logic                we;
        logic                w_occupied;
        logic [CELL_X_W-1:0] x;
        logic [CELL_Y_W-1:0] y;
    } cell_req_t;

endpackage : occupancy_grid_pkg
`default_nettype wire

// File: rtl/occupancy_grid_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request at or after the pointer, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_id,
    output logic            o_valid
);

    int              v_sum;
    logic [ID_W-1:0] v_idx;

    // Scan from the pointer upward; the first hit wins and later hits are masked
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_valid    = 1'b0;
        v_sum      = 0;
        v_idx      = '0;
        for (int off = 0; off < N; off++) begin
            v_sum = int'(i_ptr) + off;
            if (v_sum >= N) begin
                v_sum = v_sum - N;
            end
            v_idx = ID_W'(v_sum);
            if (!o_valid && i_req[v_idx]) begin
                o_valid        = 1'b1;
                o_grant[v_idx] = 1'b1;
                o_grant_id     = v_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/occupancy_grid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : occupancy_grid_arbiter
//  Description : Round-robin sharing of one single-outstanding occupancy-grid
//                port between NUM_REQ requesters, with completion routing and
//                a sticky watchdog for a grid that never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module occupancy_grid_arbiter
    import occupancy_grid_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int GRID_WIDTH_LOG2  = CELL_X_W,
    parameter int GRID_HEIGHT_LOG2 = CELL_Y_W,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    i_req_vld,
    output logic [NUM_REQ-1:0]                    o_req_rdy,
    input  logic [NUM_REQ-1:0]                    i_req_we,
    input  logic [NUM_REQ-1:0]                    i_req_w_occupied,
    input  logic [NUM_REQ*GRID_WIDTH_LOG2-1:0]    i_req_cell_x,
    input  logic [NUM_REQ*GRID_HEIGHT_LOG2-1:0]   i_req_cell_y,
    output logic [NUM_REQ-1:0]                    o_rsp_vld,
    output logic                                  o_rsp_occupied,
    output logic [GRID_WIDTH_LOG2-1:0]            o_grid_cell_x,
    output logic [GRID_HEIGHT_LOG2-1:0]           o_grid_cell_y,
    output logic                                  o_grid_we,
    output logic                                  o_grid_w_occupied,
    output logic                                  o_grid_vld_in,
    input  logic                                  i_grid_rdy,
    input  logic                                  i_grid_vld_out,
    input  logic                                  i_grid_r_occupied,
    output logic                                  o_busy,
    output logic                                  o_err_timeout
);

    localparam int ID_W = $clog2(NUM_REQ);
    // Watchdog counter is at least 8 bits and always wide enough to hold the limit
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] c_id_last = ID_W'(NUM_REQ - 1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    cell_req_t        r_req;
    cell_req_t        w_sel_req;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [WD_W-1:0]  r_wdog;
    logic [NUM_REQ-1:0] r_rsp_vld;
    logic             r_rsp_occ;
    logic             r_err;

    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_arb_valid;
    logic               w_accept;
    logic               w_done;
    logic               w_timeout;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .i_req      (i_req_vld),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant_oh),
        .o_grant_id (w_grant_id),
        .o_valid    (w_arb_valid)
    );

    // A grant is only offered from IDLE while the grid reports ready
    assign w_accept  = rst_n && (r_state == IDLE) && i_grid_rdy && w_arb_valid;
    assign o_req_rdy = w_accept ? w_grant_oh : '0;

    // Reads finish on returned data, writes finish when the grid goes ready again
    assign w_done    = (r_state == WAIT) &&
                       (r_req.we ? i_grid_rdy : i_grid_vld_out);
    // Completion takes priority over a watchdog expiry landing in the same cycle
    assign w_timeout = (r_state == WAIT) && !w_done && (r_wdog == c_wd_last);

    // Mux the granted requester's fields into the request record
    always_comb begin
        w_sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_req.we         = i_req_we[i];
                w_sel_req.w_occupied = i_req_w_occupied[i];
                w_sel_req.x          = CELL_X_W'(i_req_cell_x[i*GRID_WIDTH_LOG2 +: GRID_WIDTH_LOG2]);
                w_sel_req.y          = CELL_Y_W'(i_req_cell_y[i*GRID_HEIGHT_LOG2 +: GRID_HEIGHT_LOG2]);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs; HOLD never looks at grid ready
    // because the grid's registered ready may still read high after issue
    always_comb begin
        w_next_state  = r_state;
        o_grid_vld_in = 1'b0;
        o_busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                o_grid_vld_in = 1'b1;
                w_next_state  = HOLD;
            end
            HOLD: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (w_done || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request capture, pointer advance, watchdog and registered completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req     <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_wdog    <= '0;
            r_rsp_vld <= '0;
            r_rsp_occ <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rsp_vld <= '0;
            r_rsp_occ <= 1'b0;

            if (w_accept) begin
                r_req    <= w_sel_req;
                r_owner  <= w_grant_id;
                r_rr_ptr <= (w_grant_id == c_id_last) ? '0 : w_grant_id + ID_W'(1);
            end

            if (r_state == HOLD) begin
                r_wdog <= '0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
            end

            if (w_done || w_timeout) begin
                r_rsp_vld[r_owner] <= 1'b1;
                // An expired watchdog reports the cell as blocked
                r_rsp_occ <= w_timeout ? 1'b1 : (r_req.we ? 1'b0 : i_grid_r_occupied);
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_rsp_vld         = r_rsp_vld;
    assign o_rsp_occupied    = r_rsp_occ;
    assign o_err_timeout     = r_err;
    assign o_grid_cell_x     = GRID_WIDTH_LOG2'(r_req.x);
    assign o_grid_cell_y     = GRID_HEIGHT_LOG2'(r_req.y);
    assign o_grid_we         = r_req.we;
    assign o_grid_w_occupied = r_req.w_occupied;

endmodule : occupancy_grid_arbiter
`default_nettype wire

// File: tb/tb_occupancy_grid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_occupancy_grid_arbiter
//  Description : Directed bench for occupancy_grid_arbiter: a vector table of
//                transactions plus hand sequences for timeout and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_occupancy_grid_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] i_req_vld, o_req_rdy, i_req_we, i_req_w_occupied, o_rsp_vld;
    logic [NR*8-1:0] i_req_cell_x, i_req_cell_y;
    logic          o_rsp_occupied;
    logic [7:0]    o_grid_cell_x, o_grid_cell_y;
    logic          o_grid_we, o_grid_w_occupied, o_grid_vld_in;
    logic          i_grid_rdy, i_grid_vld_out, i_grid_r_occupied;
    logic          o_busy, o_err_timeout;

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;

    int xs [NR] = '{3, 17, 255, 200};
    int ys [NR] = '{5, 66, 0, 129};

    typedef struct {
        logic [3:0] vld;
        logic       we;
        logic       wocc;
        logic       rd;
        int         lat;
        logic       stale;
        int         exp_id;
        logic       exp_occ;
    } vec_t;

    vec_t vecs [15];

    occupancy_grid_arbiter #(
        .NUM_REQ          (NR),
        .GRID_WIDTH_LOG2  (8),
        .GRID_HEIGHT_LOG2 (8),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_vld         (i_req_vld),
        .o_req_rdy         (o_req_rdy),
        .i_req_we          (i_req_we),
        .i_req_w_occupied  (i_req_w_occupied),
        .i_req_cell_x      (i_req_cell_x),
        .i_req_cell_y      (i_req_cell_y),
        .o_rsp_vld         (o_rsp_vld),
        .o_rsp_occupied    (o_rsp_occupied),
        .o_grid_cell_x     (o_grid_cell_x),
        .o_grid_cell_y     (o_grid_cell_y),
        .o_grid_we         (o_grid_we),
        .o_grid_w_occupied (o_grid_w_occupied),
        .o_grid_vld_in     (o_grid_vld_in),
        .i_grid_rdy        (i_grid_rdy),
        .i_grid_vld_out    (i_grid_vld_out),
        .i_grid_r_occupied (i_grid_r_occupied),
        .o_busy            (o_busy),
        .o_err_timeout     (o_err_timeout)
    );

    always #5 clk = ~clk;

    // Count every completion pulse seen
    always @(negedge clk) begin
        if (o_rsp_vld != '0) rsp_cnt = rsp_cnt + 1;
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a request, check the grant, then follow it through ISSUE/HOLD into WAIT
    task automatic issue_req(input string nm, input logic [3:0] vld, input logic we,
                             input logic wocc, input logic stale, input int exp_id);
        tick();
        i_req_vld        = vld;
        i_req_we         = {NR{we}};
        i_req_w_occupied = {NR{wocc}};
        i_grid_rdy       = 1'b1;
        i_grid_vld_out   = 1'b0;
        #1;
        chk({nm, " req_rdy"}, 32'(o_req_rdy), oh(exp_id));
        rsp_cnt = 0;
        tick();
        i_req_vld = '0;
        chk({nm, " issue vld_in"}, 32'(o_grid_vld_in), 32'd1);
        chk({nm, " cell_x"}, 32'(o_grid_cell_x), 32'(xs[exp_id]));
        chk({nm, " cell_y"}, 32'(o_grid_cell_y), 32'(ys[exp_id]));
        chk({nm, " grid_we"}, 32'(o_grid_we), 32'(we));
        chk({nm, " grid_wocc"}, 32'(o_grid_w_occupied), 32'(wocc));
        if (!stale) i_grid_rdy = 1'b0;
        tick();
        chk({nm, " hold vld_in"}, 32'(o_grid_vld_in), 32'd0);
        chk({nm, " hold busy"}, 32'(o_busy), 32'd1);
        tick();
        i_grid_rdy = 1'b0;
    endtask

    // Let the grid answer after lat more cycles and check the routed response
    task automatic finish_req(input string nm, input logic we, input logic rd,
                              input int lat, input int exp_id, input logic exp_occ);
        repeat (lat) tick();
        chk({nm, " early rsp"}, 32'(rsp_cnt), 32'd0);
        i_grid_rdy = 1'b1;
        if (!we) begin
            i_grid_vld_out    = 1'b1;
            i_grid_r_occupied = rd;
        end
        tick();
        i_grid_vld_out = 1'b0;
        chk({nm, " rsp_vld"}, 32'(o_rsp_vld), oh(exp_id));
        chk({nm, " rsp_occ"}, 32'(o_rsp_occupied), 32'(exp_occ));
        chk({nm, " busy after"}, 32'(o_busy), 32'd0);
        tick();
        chk({nm, " rsp count"}, 32'(rsp_cnt), 32'd1);
    endtask

    initial begin
        //            vld      we    wocc  rd    lat stale id exp_occ
        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b1};
        vecs[1]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 1, 1'b0, 2, 1'b0};
        vecs[2]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3, 1'b0};
        vecs[3]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 1'b1};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0};
        vecs[5]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 3, 1'b0, 2, 1'b0};
        vecs[6]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 1, 1'b1, 3, 1'b0};
        vecs[7]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1};
        vecs[8]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1, 1'b0};
        vecs[9]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2, 1'b0};
        vecs[10] = '{4'b1111, 1'b0, 1'b0, 1'b1, 1, 1'b0, 3, 1'b1};
        vecs[11] = '{4'b0110, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b1};
        vecs[12] = '{4'b0011, 1'b1, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[13] = '{4'b0101, 1'b0, 1'b0, 1'b1, 2, 1'b0, 2, 1'b1};
        vecs[14] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1, 1'b0, 3, 1'b0};

        for (int i = 0; i < NR; i++) begin
            i_req_cell_x[i*8 +: 8] = 8'(xs[i]);
            i_req_cell_y[i*8 +: 8] = 8'(ys[i]);
        end
        rst_n             = 1'b0;
        i_req_vld         = 4'b1111;
        i_req_we          = '0;
        i_req_w_occupied  = '0;
        i_grid_rdy        = 1'b1;
        i_grid_vld_out    = 1'b0;
        i_grid_r_occupied = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset req_rdy", 32'(o_req_rdy), 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset vld_in", 32'(o_grid_vld_in), 32'd0);
        chk("reset rsp_vld", 32'(o_rsp_vld), 32'd0);
        chk("reset err", 32'(o_err_timeout), 32'd0);
        chk("reset cell_x", 32'(o_grid_cell_x), 32'd0);
        i_req_vld = '0;
        rst_n     = 1'b1;

        // Table-driven transactions: single read, write, round-robin, stale ready
        for (int v = 0; v < 15; v++) begin
            issue_req($sformatf("vec%0d", v), vecs[v].vld, vecs[v].we, vecs[v].wocc,
                      vecs[v].stale, vecs[v].exp_id);
            finish_req($sformatf("vec%0d", v), vecs[v].we, vecs[v].rd, vecs[v].lat,
                       vecs[v].exp_id, vecs[v].exp_occ);
        end

        // Watchdog: requester 1 reads, grid never answers (ptr 0 -> grant 1)
        issue_req("tmo", 4'b0010, 1'b0, 1'b0, 1'b0, 1);
        repeat (TO - 1) tick();
        chk("tmo no rsp before limit", 32'(rsp_cnt), 32'd0);
        chk("tmo err before limit", 32'(o_err_timeout), 32'd0);
        tick();
        chk("tmo rsp_vld", 32'(o_rsp_vld), 32'b0010);
        chk("tmo rsp_occ", 32'(o_rsp_occupied), 32'd1);
        chk("tmo err set", 32'(o_err_timeout), 32'd1);
        chk("tmo busy", 32'(o_busy), 32'd0);
        // Normal service afterwards; flag stays sticky
        issue_req("post_tmo", 4'b0100, 1'b0, 1'b0, 1'b0, 2);
        finish_req("post_tmo", 1'b0, 1'b0, 1, 2, 1'b0);
        chk("tmo err sticky", 32'(o_err_timeout), 32'd1);

        // Reset mid-WAIT during a read from requester 1 (ptr 3 -> grant 1)
        issue_req("rst", 4'b0010, 1'b0, 1'b0, 1'b0, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst req_rdy", 32'(o_req_rdy), 32'd0);
        chk("rst rsp_vld", 32'(o_rsp_vld), 32'd0);
        chk("rst err cleared", 32'(o_err_timeout), 32'd0);
        chk("rst cell_x", 32'(o_grid_cell_x), 32'd0);
        // Spurious grid data outside WAIT produces nothing
        i_grid_rdy        = 1'b1;
        i_grid_vld_out    = 1'b1;
        i_grid_r_occupied = 1'b1;
        tick();
        i_grid_vld_out = 1'b0;
        tick();
        chk("spurious no rsp", 32'(rsp_cnt), 32'd0);
        // Pointer back at 0 after reset
        i_req_vld = 4'b1111;
        #1;
        chk("rst ptr grant", 32'(o_req_rdy), 32'b0001);
        i_req_vld = '0;
        issue_req("post_rst", 4'b1000, 1'b1, 1'b1, 1'b0, 3);
        finish_req("post_rst", 1'b1, 1'b0, 2, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_occupancy_grid_arbiter
`default_nettype wire
